// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite line buffer.
package sprite_pkg;

  localparam int               LB_XW        = 8;
  localparam int               LB_DW        = 8;
  localparam logic [8:0]       LB_SWAP_HPOS = 9'd371;
  localparam logic [LB_DW-1:0] TRANSPARENT  = 8'h00;

  typedef enum logic {
    LB_INIT,
    LB_RUN
  } lb_state_t;

endpackage

// File: rtl/linebuf_ram.sv
// Two-port synchronous RAM, each port with its own read and write address.
// Reads return the pre-write contents; a port B write wins a same-address collision.
module linebuf_ram #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          PCLK,
  input  logic [AW-1:0] a_raddr,
  input  logic          a_we,
  input  logic [AW-1:0] a_waddr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  input  logic [AW-1:0] b_raddr,
  input  logic          b_we,
  input  logic [AW-1:0] b_waddr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: the array has no reset; the owner clears it with an explicit sweep instead.
  always_ff @(posedge PCLK) begin
    a_rdata <= mem[a_raddr];
    b_rdata <= mem[b_raddr];
    if (a_we) mem[a_waddr] <= a_wdata;
    if (b_we) mem[b_waddr] <= b_wdata;
  end

endmodule

// File: rtl/sprite_linebuf.sv
// Double-buffered sprite line buffer: sprite engine fills the write bank with
// first-written-wins priority while the read bank is scanned out and cleared.
module sprite_linebuf
  import sprite_pkg::*;
#(
  parameter int         XW        = LB_XW,
  parameter int         DW        = LB_DW,
  parameter logic [8:0] SWAP_HPOS = LB_SWAP_HPOS
) (
  input  logic          PCLK,
  input  logic          RESET,
  input  logic [8:0]    HPOS,
  input  logic          WR_EN,
  input  logic [8:0]    WR_X,
  input  logic [DW-1:0] WR_D,
  output logic          WR_RDY,
  output logic          LINE_ST,
  output logic [DW-1:0] OPIX,
  output logic          OOPQ
);

  localparam int AW = XW + 1;

  lb_state_t     state, state_nxt;
  logic [XW-1:0] init_cnt;
  logic          in_init, run;
  logic          wbank, rbank, swap;

  logic          wr_take, commit;
  logic          s1_valid, lc_valid;
  logic [AW-1:0] s1_addr, lc_addr;
  logic [DW-1:0] s1_data, lc_data, old_pix;

  logic          rd_take, r1_valid;
  logic [AW-1:0] r1_addr;

  logic          a_we, b_we;
  logic [AW-1:0] a_raddr, a_waddr, b_raddr, b_waddr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata;

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) state <= LB_INIT;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb assigns its outputs a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      LB_INIT: if (init_cnt == '1) state_nxt = LB_RUN;
      LB_RUN:  state_nxt = LB_RUN;
      default: state_nxt = LB_INIT;
    endcase
  end

  always_comb begin
    in_init = (state == LB_INIT);
    run     = (state == LB_RUN);
    WR_RDY  = run;
  end

  assign swap  = run && (HPOS == SWAP_HPOS);
  assign rbank = ~wbank;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      init_cnt <= '0;
      wbank    <= 1'b0;
      LINE_ST  <= 1'b0;
    end else begin
      if (in_init) init_cnt <= init_cnt + 1'b1;
      LINE_ST <= swap;
      if (swap) wbank <= ~wbank;
    end
  end

  // Write path: read the old pixel on acceptance, commit next cycle only if it was
  // transparent. The last commit is forwarded to cover a back-to-back same-address write.
  assign wr_take = WR_EN && WR_RDY && !WR_X[8] && (WR_D != DW'(TRANSPARENT));
  assign old_pix = (lc_valid && (lc_addr == s1_addr)) ? lc_data : a_rdata;
  assign commit  = s1_valid && (old_pix == DW'(TRANSPARENT));

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
      lc_valid <= 1'b0;
      lc_addr  <= '0;
      lc_data  <= '0;
    end else begin
      s1_valid <= wr_take;
      s1_addr  <= {wbank, WR_X[XW-1:0]};
      s1_data  <= WR_D;
      lc_valid <= commit;
      lc_addr  <= s1_addr;
      lc_data  <= s1_data;
    end
  end

  // Read path: the bank is captured with the address so the clear follows it across a swap.
  assign rd_take = run && !HPOS[8];

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      r1_valid <= 1'b0;
      r1_addr  <= '0;
      OPIX     <= '0;
      OOPQ     <= 1'b0;
    end else begin
      r1_valid <= rd_take;
      r1_addr  <= {rbank, HPOS[XW-1:0]};
      OPIX     <= r1_valid ? b_rdata : '0;
      OOPQ     <= r1_valid && (b_rdata != '0);
    end
  end

  always_comb begin
    a_raddr = {wbank, WR_X[XW-1:0]};
    b_raddr = {rbank, HPOS[XW-1:0]};
    a_we    = commit;
    a_waddr = s1_addr;
    a_wdata = s1_data;
    b_we    = r1_valid;
    b_waddr = r1_addr;
    b_wdata = '0;
    if (in_init) begin
      a_we    = 1'b1;
      a_waddr = {1'b0, init_cnt};
      a_wdata = '0;
      b_we    = 1'b1;
      b_waddr = {1'b1, init_cnt};
    end
  end

  linebuf_ram #(.AW(AW), .DW(DW)) u_ram (
    .PCLK    (PCLK),
    .a_raddr (a_raddr),
    .a_we    (a_we),
    .a_waddr (a_waddr),
    .a_wdata (a_wdata),
    .a_rdata (a_rdata),
    .b_raddr (b_raddr),
    .b_we    (b_we),
    .b_waddr (b_waddr),
    .b_wdata (b_wdata),
    .b_rdata (b_rdata)
  );

endmodule

// File: tb/tb_sprite_linebuf.sv
// Randomised bench for sprite_linebuf: realistic HPOS sweep, random sprite writes,
// an array-level reference model, and literal pins for the key scenarios.
module tb_sprite_linebuf;

  localparam int LINE_LEN = 396;
  localparam int N_LINES  = 14;

  logic       PCLK  = 1'b0;
  logic       RESET = 1'b0;
  logic [8:0] HPOS  = '0;
  logic       WR_EN = 1'b0;
  logic [8:0] WR_X  = '0;
  logic [7:0] WR_D  = '0;
  logic       WR_RDY, LINE_ST, OOPQ;
  logic [7:0] OPIX;

  sprite_linebuf dut (
    .PCLK    (PCLK),
    .RESET   (RESET),
    .HPOS    (HPOS),
    .WR_EN   (WR_EN),
    .WR_X    (WR_X),
    .WR_D    (WR_D),
    .WR_RDY  (WR_RDY),
    .LINE_ST (LINE_ST),
    .OPIX    (OPIX),
    .OOPQ    (OOPQ)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: two plain pixel arrays, writes applied at acceptance.
  logic [7:0] mem [2][256];
  int         init_edges;
  bit         m_wbank;
  logic [7:0] stage_v;
  logic [7:0] exp_opix, nxt_opix;
  bit         exp_wr_rdy, nxt_wr_rdy, exp_line_st, nxt_line_st;

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 256; i++) mem[b][i] = 8'h00;
    init_edges  = 0;
    m_wbank     = 1'b0;
    stage_v     = 8'h00;
    nxt_opix    = 8'h00;
    nxt_wr_rdy  = 1'b0;
    nxt_line_st = 1'b0;
  endtask

  task automatic model_step();
    bit         run;
    logic [7:0] v;
    int         x, h;
    if (RESET) begin
      model_reset();
      return;
    end
    run = (init_edges >= 256);
    x   = int'(WR_X[7:0]);
    if (WR_EN && run && !WR_X[8] && WR_D != 8'h00 && mem[m_wbank][x] == 8'h00)
      mem[m_wbank][x] = WR_D;
    v = 8'h00;
    if (run && !HPOS[8]) begin
      h = int'(HPOS[7:0]);
      v = mem[!m_wbank][h];
      mem[!m_wbank][h] = 8'h00;
    end
    nxt_opix    = stage_v;
    stage_v     = v;
    nxt_line_st = run && (HPOS == 9'd371);
    if (nxt_line_st) m_wbank = !m_wbank;
    if (init_edges < 256) init_edges++;
    nxt_wr_rdy = (init_edges >= 256);
  endtask

  // HPOS / line history so the compare process knows what OPIX belongs to.
  logic [8:0] h_cur = '0, h_d1 = '0, h_d2 = '0;
  int         l_cur = -1, l_d1 = -1, l_d2 = -1;

  int cmp_cyc   = 0;
  int low_cnt   = 0;
  bit counting  = 1'b0;
  int last_ls   = -1;

  always @(negedge PCLK) begin
    cmp_cyc++;
    check("opix", OPIX, exp_opix);
    check("oopq", OOPQ, exp_opix != 8'h00);
    check("wr_rdy", WR_RDY, exp_wr_rdy);
    check("line_st", LINE_ST, exp_line_st);

    if (l_d2 >= 0 && l_d2 <= 1 && !h_d2[8]) check("pin_first_lines_blank", OPIX, 8'h00);
    if (l_d2 == 4) begin
      if (h_d2 == 9'd10) begin
        check("pin_l4_x10_opix", OPIX, 8'h35);
        check("pin_l4_x10_oopq", OOPQ, 1'b1);
      end
      if (h_d2 == 9'd20)  check("pin_l4_x20_first_wins_b2b", OPIX, 8'h11);
      if (h_d2 == 9'd5)   check("pin_l4_x5_offscreen_drop", OPIX, 8'h00);
      if (h_d2 == 9'd30)  check("pin_l4_x30_zero_drop", OPIX, 8'h00);
      if (h_d2 == 9'd40)  check("pin_l4_x40_swap_edge", OPIX, 8'h5A);
      if (h_d2 == 9'h1F0) check("pin_l4_offscreen_read", OPIX, 8'h00);
    end
    if (l_d2 == 5 && h_d2 == 9'd10) check("pin_l5_x10_cleared", OPIX, 8'h00);
    if (l_d2 == 6) begin
      if (h_d2 == 9'd10) check("pin_l6_x10_reuse_cleared", OPIX, 8'h00);
      if (h_d2 == 9'd20) check("pin_l6_x20_first_wins_gap", OPIX, 8'h11);
    end

    if (RESET) begin
      low_cnt  = 0;
      counting = 1'b1;
    end else if (counting) begin
      if (!WR_RDY) low_cnt++;
      else begin
        check("init_length", low_cnt, 256);
        counting = 1'b0;
      end
    end

    if (RESET) last_ls = -1;
    else if (LINE_ST) begin
      if (last_ls >= 0) check("line_st_period", cmp_cyc - last_ls, LINE_LEN);
      last_ls = cmp_cyc;
    end
  end

  initial begin
    int hcnt    = 0;
    int line_no = 0;
    RESET = 1'b1;
    model_reset();
    exp_opix    = 8'h00;
    exp_wr_rdy  = 1'b0;
    exp_line_st = 1'b0;

    for (int cyc = 0; cyc < N_LINES * LINE_LEN; cyc++) begin
      @(posedge PCLK);
      #1;
      exp_opix    = nxt_opix;
      exp_wr_rdy  = nxt_wr_rdy;
      exp_line_st = nxt_line_st;

      if (cyc == 3 || (line_no == 9 && hcnt == 153)) RESET = 1'b0;

      HPOS = (hcnt < 24) ? 9'(hcnt + 488) : 9'(hcnt - 24);
      h_d2 = h_d1; h_d1 = h_cur; h_cur = HPOS;
      l_d2 = l_d1; l_d1 = l_cur; l_cur = line_no;

      WR_EN = 1'b0;
      WR_X  = '0;
      WR_D  = '0;
      if (line_no == 3 && hcnt == 50)       begin WR_EN = 1'b1; WR_X = 9'd10;  WR_D = 8'h35; end
      else if (line_no == 3 && hcnt == 60)  begin WR_EN = 1'b1; WR_X = 9'd20;  WR_D = 8'h11; end
      else if (line_no == 3 && hcnt == 61)  begin WR_EN = 1'b1; WR_X = 9'd20;  WR_D = 8'h22; end
      else if (line_no == 3 && hcnt == 70)  begin WR_EN = 1'b1; WR_X = 9'h105; WR_D = 8'h44; end
      else if (line_no == 3 && hcnt == 71)  begin WR_EN = 1'b1; WR_X = 9'd30;  WR_D = 8'h00; end
      else if (line_no == 3 && hcnt == 395) begin WR_EN = 1'b1; WR_X = 9'd40;  WR_D = 8'h5A; end
      else if (line_no == 5 && hcnt == 60)  begin WR_EN = 1'b1; WR_X = 9'd20;  WR_D = 8'h11; end
      else if (line_no == 5 && hcnt == 65)  begin WR_EN = 1'b1; WR_X = 9'd20;  WR_D = 8'h22; end
      else if (line_no != 0 && $urandom_range(0, 2) == 0) begin
        WR_EN = 1'b1;
        WR_X  = 9'($urandom_range(64, 319));
        WR_D  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      end

      model_step();

      if (line_no == 9 && hcnt == 150) begin
        #1;
        RESET = 1'b1;
        #1;
        check("async_rst_wr_rdy", WR_RDY, 1'b0);
        check("async_rst_opix", OPIX, 8'h00);
        check("async_rst_oopq", OOPQ, 1'b0);
        check("async_rst_line_st", LINE_ST, 1'b0);
        model_reset();
        exp_opix    = 8'h00;
        exp_wr_rdy  = 1'b0;
        exp_line_st = 1'b0;
      end

      hcnt++;
      if (hcnt == LINE_LEN) begin
        hcnt = 0;
        line_no++;
      end
    end

    @(posedge PCLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
